// File: rtl/rr_arbiter4_pkg.sv
// Shared constants for the four-client round-robin arbiter.
// The reset value of last_id places client 0 first in the search order.
package rr_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int         NUM_REQ     = 4;
    localparam logic [1:0] LAST_ID_RST = 2'd3;

endpackage

// File: rtl/rr_arbiter4_grant_decoder.sv
// Combinational 2-to-4 one-hot decoder with enable; produces the grant vector.
module grant_decoder (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] o
);

    always_comb begin
        o = 4'b0000;
        if (en) begin
            o = 4'b0001 << sel;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time (MAX_HOLD).
// The holder is preempted after MAX_HOLD cycles only when another client is waiting.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] last_id;
    logic [3:0] hold_cnt;
    logic [3:0] others;

    // First set bit of mask searching base+1, base+2, base+3, then base itself.
    function automatic logic [1:0] next_winner(input logic [1:0] base, input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] result;
        result = base;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = base + 2'(k);
            if (mask[idx]) begin
                result = idx;
            end
        end
        return result;
    endfunction

    assign others = req & ~(4'b0001 << gnt_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt_id   <= 2'd0;
            last_id  <= LAST_ID_RST;
            hold_cnt <= 4'd0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (state == ST_IDLE) begin
                if (|req) begin
                    state    <= ST_GRANT;
                    gnt_id   <= next_winner(last_id, req);
                    hold_cnt <= 4'd0;
                end
            end else if (!req[gnt_id]) begin
                last_id <= gnt_id;
                if (|others) begin
                    gnt_id   <= next_winner(gnt_id, others);
                    hold_cnt <= 4'd0;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (hold_cnt == HOLD_LAST) begin
                // With nobody waiting the counter simply stays saturated.
                if (|others) begin
                    last_id  <= gnt_id;
                    gnt_id   <= next_winner(gnt_id, others);
                    hold_cnt <= 4'd0;
                    preempt  <= 1'b1;
                end
            end else begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    assign gnt_valid = (state == ST_GRANT);

    grant_decoder u_grant_decoder (
        .sel (gnt_id),
        .en  (gnt_valid),
        .o   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, multi-cycle corner
// sequences, and randomized requests checked against a queue-free rotation model.
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t vecs[12];

    // Reference model state: owner < 0 means idle.
    int         m_owner;
    int         m_last;
    int         m_held;
    logic [1:0] m_id;
    logic       m_pre;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rr_pick(input int base, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_id    = 2'd0;
        m_pre   = 1'b0;
    endfunction

    // m_held counts cycles the current owner has visibly held the grant.
    function automatic void model_step(input logic [3:0] r);
        logic [3:0] waiting;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                m_owner = rr_pick(m_last, r);
                m_held  = 1;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = rr_pick(m_last, r);
            m_held  = 1;
        end else begin
            waiting = r & ~(4'b0001 << m_owner);
            if (m_held >= MAX_HOLD && waiting != 4'b0000) begin
                m_last  = m_owner;
                m_owner = rr_pick(m_last, waiting);
                m_held  = 1;
                m_pre   = 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end
        if (m_owner >= 0) m_id = 2'(m_owner);
    endfunction

    function automatic logic [3:0] model_gnt();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    initial begin
        logic [3:0] r;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;

        //            req      gnt      id     valid pre
        vecs[0]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[6]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};

        do_reset();
        check_output("reset_gnt", 8'(gnt), 8'h0);
        check_output("reset_gnt_id", 8'(gnt_id), 8'h0);
        check_output("reset_valid", 8'(gnt_valid), 8'h0);
        check_output("reset_preempt", 8'(preempt), 8'h0);

        // Release handoff, wrap-around and idle return from one reset.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].req);
            check_output($sformatf("vec%0d_gnt", i), 8'(gnt), 8'(vecs[i].gnt));
            check_output($sformatf("vec%0d_id", i), 8'(gnt_id), 8'(vecs[i].id));
            check_output($sformatf("vec%0d_valid", i), 8'(gnt_valid), 8'(vecs[i].valid));
            check_output($sformatf("vec%0d_pre", i), 8'(preempt), 8'(vecs[i].pre));
            if (i == 7) check_output("wrap_last_id", 8'(dut.last_id), 8'd3);
        end

        // Reset priority with everyone requesting: rotate every MAX_HOLD cycles.
        do_reset();
        for (int c = 1; c <= 33; c++) begin
            apply_stimulus(4'b1111);
            check_output($sformatf("prio_c%0d_gnt", c), 8'(gnt), 8'(4'b0001 << (((c - 1) / MAX_HOLD) % 4)));
            check_output($sformatf("prio_c%0d_pre", c), 8'(preempt),
                         8'((c > 1 && (c - 1) % MAX_HOLD == 0) ? 1 : 0));
        end

        // Sole requester saturates, then a newcomer forces an immediate preempt.
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            apply_stimulus(4'b0010);
            check_output($sformatf("sole_c%0d_gnt", c), 8'(gnt), 8'h2);
            check_output($sformatf("sole_c%0d_pre", c), 8'(preempt), 8'h0);
        end
        check_output("sole_hold_sat", 8'(dut.hold_cnt), 8'(MAX_HOLD - 1));
        apply_stimulus(4'b0011);
        check_output("sole_then_pre_gnt", 8'(gnt), 8'h1);
        check_output("sole_then_pre_pre", 8'(preempt), 8'h1);

        // Asynchronous reset while client 2 holds the grant.
        do_reset();
        apply_stimulus(4'b0100);
        check_output("midrst_pre_gnt", 8'(gnt), 8'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_gnt_cleared", 8'(gnt), 8'h0);
        check_output("midrst_valid_cleared", 8'(gnt_valid), 8'h0);
        req = 4'b0110;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(4'b0110);
        check_output("midrst_first_gnt", 8'(gnt), 8'h2);

        // Randomized sticky requests against the reference model.
        do_reset();
        model_reset();
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 99) == 0) r = 4'b0000;
            apply_stimulus(r);
            model_step(r);
            check_output($sformatf("rand_c%0d_gnt", c), 8'(gnt), 8'(model_gnt()));
            check_output($sformatf("rand_c%0d_id", c), 8'(gnt_id), 8'(m_id));
            check_output($sformatf("rand_c%0d_valid", c), 8'(gnt_valid), 8'((m_owner >= 0) ? 1 : 0));
            check_output($sformatf("rand_c%0d_pre", c), 8'(preempt), 8'(m_pre));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with a bounded hold time. It shares one resource among four clients and produces a registered one-hot grant through a 2-to-4 decode of the winning index. It sits in front of any shared datapath (bus, ALU port, memory) that needs mutually exclusive access with fairness and no starvation.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while other requests are pending; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in [3:0]: request per client, level-sensitive; a client holds it high for the whole transaction.
- `gnt` out [3:0]: one-hot grant, registered; all zero when idle.
- `gnt_id` out [1:0]: index of the current grantee; holds its last value while idle.
- `gnt_valid` out 1: high when `gnt` is non-zero.
- `preempt` out 1: one-cycle pulse, high in the cycle a new grant starts because of a `MAX_HOLD` timeout.

## Operation
- FSM has two states, IDLE and GRANT. Registered state consists of `state`, `gnt_id`, `last_id` and `hold_cnt` [3:0].
- Round-robin search order is `last_id+1`, `last_id+2`, `last_id+3`, `last_id`, using mod-4 wrap-around (3+1 wraps to 0).
- IDLE:
  - If `req` is non-zero, pick the winner in search order, go to GRANT and set `hold_cnt` to 0.
  - If `req` is zero, stay in IDLE.
- GRANT with `req[gnt_id]`=0 (release):
  - Set `last_id` to `gnt_id`.
  - If other requests are pending, grant the next one in search order directly; there is no dead cycle.
  - Otherwise go to IDLE.
- GRANT with `req[gnt_id]`=1 and `hold_cnt`==`MAX_HOLD`-1:
  - If any other request is pending, preempt: set `last_id` to `gnt_id`, grant the next one in search order and pulse `preempt`.
  - If no other request is pending, keep the grant and hold `hold_cnt` (saturate).
- GRANT otherwise: increment `hold_cnt`.
- Any new grant clears `hold_cnt` to 0.
- `gnt` is the 2-to-4 decode of `gnt_id`, gated by GRANT. At most one bit is ever set.
- Requests arriving in the same cycle as a release take part in that cycle's arbitration.

## Timing
- Reset values:
  - `state`=IDLE; `gnt`=4'b0000; `gnt_id`=2'd0; `gnt_valid`=0; `preempt`=0.
  - `last_id`=2'd3, so after reset client 0 has first priority.
  - `hold_cnt`=0.
- Grant latency is 1 cycle: `req` sampled high at edge n gives `gnt` at edge n+1.
- Release latency is 1 cycle: `req[i]` dropped before edge n removes `gnt[i]` at edge n, and the next grant appears at the same edge.
- A grantee holds the grant for at most `MAX_HOLD` cycles while others wait.
- Worst-case wait for any requester is 3×`MAX_HOLD`+1 cycles.
- `rst_n` asserted mid-grant clears `gnt` immediately (asynchronously). The first grant after deassertion follows the reset-priority order.
- `MAX_HOLD`=1 degenerates to rotating one-cycle grants whenever two or more clients request.
- `req` glitching low for one cycle counts as a release; the grant is lost.

## Structure
- Shared constants file holds:
  - state encodings (`ST_IDLE`=1'b0, `ST_GRANT`=1'b1);
  - `NUM_REQ`=4;
  - the reset value of `last_id`.
- One sub-module, `grant_decoder`: a purely combinational 2-to-4 decoder (`sel[1:0]`, `en` → `o[3:0]`), instantiated once to drive `gnt`.
- Next-winner selection is a combinational function of `last_id`/`gnt_id` and the pending mask. It stays inside `rr_arbiter4`.

## Test plan
- Reset priority:
  - Stimulus: after reset, `req`=4'b1111 at edge 1.
  - Response: `gnt`=4'b0001 at edge 2, then 4'b0010, 4'b0100 and 4'b1000 at 8-cycle intervals, with `preempt` pulsing at each change.
- Release handoff:
  - Stimulus: `req`=4'b0101 with client 0 granted; drop `req[0]` after 3 cycles.
  - Response: `gnt` goes 4'b0001→4'b0100 at the same edge with no idle cycle, and `preempt`=0.
- Sole requester:
  - Stimulus: `req`=4'b0010 held for 20 cycles.
  - Response: `gnt`=4'b0010 throughout, `hold_cnt` saturates at 7, `preempt` never asserts.
- Wrap-around:
  - Stimulus: client 3 granted; `req`=4'b1001, then drop `req[3]`.
  - Response: next `gnt`=4'b0001 and `last_id`=3.
- Reset mid-grant:
  - Stimulus: assert `rst_n`=0 mid-cycle while `gnt`=4'b0100.
  - Response: `gnt`=0 before the next edge. After release with `req`=4'b0110, the first grant is 4'b0010.
- Idle return:
  - Stimulus: every request drops.
  - Response: `gnt_valid`=0 at the next edge, and `gnt_id` keeps its last value.
